// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad matrix scanner: FSM states,
// key-code width and the lowest-column priority encoder.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_RELEASE
  } scan_state_t;

  function automatic int key_width(input int rows, input int cols);
    return $clog2(rows * cols);
  endfunction

  // Lowest set bit wins, so the lowest-numbered pressed column is reported.
  function automatic logic [3:0] lowest_set_index(input logic [15:0] vec);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (vec[i]) idx = i[3:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Free-running divider producing a one-clk scan tick every CLK_DIV cycles.
module keypad_tick_gen #(
  parameter int CLK_DIV = 65536
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (count == CW'(CLK_DIV - 1)) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = (count == CW'(CLK_DIV - 1));

endmodule

// File: rtl/keypad_matrix_scanner.sv
// ROWS x COLS keypad scanner with per-key debounce, typematic repeat,
// multi-key flag and a single-entry valid/ready event register.
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int CLK_DIV      = 65536,
  parameter int DEBOUNCE     = 4,
  parameter int REPEAT_DELAY = 0,
  parameter int REPEAT_RATE  = 8,
  localparam int KW          = key_width(ROWS, COLS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [COLS-1:0] col_n,
  output logic [ROWS-1:0] row_n,
  output logic [KW-1:0]   key_code,
  output logic            key_valid,
  output logic            multi_key,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [KW-1:0]   evt_code,
  output logic            evt_repeat,
  output logic            overflow,
  input  logic            ovf_clr
);

  localparam int RIW     = $clog2(ROWS);
  localparam int CIW     = $clog2(COLS);
  localparam int DW      = $clog2(DEBOUNCE + 1);
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int PW      = $clog2(REP_MAX + 1);

  logic [COLS-1:0] col_meta, col_sync, col_pressed;
  logic [15:0]     pressed_ext;
  logic            tick, any_pressed, multi_now, rep_hit, rep_armed;
  logic [CIW-1:0]  low_col, lat_col;
  logic [RIW-1:0]  row_idx, next_row;
  logic [DW-1:0]   cnt;
  logic [PW-1:0]   rep_cnt;
  logic [KW-1:0]   cur_code, new_code;
  logic            new_evt, new_repeat;
  scan_state_t     state;

  keypad_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      col_meta <= '1;
      col_sync <= '1;
    end else begin
      col_meta <= col_n;
      col_sync <= col_meta;
    end
  end

  always_comb begin
    col_pressed              = ~col_sync;
    pressed_ext              = '0;
    pressed_ext[COLS-1:0]    = col_pressed;
    any_pressed              = |col_pressed;
    low_col                  = CIW'(lowest_set_index(pressed_ext));
    multi_now                = ($countones(col_pressed) > 1);
    next_row                 = (row_idx == RIW'(ROWS - 1)) ? '0 : row_idx + RIW'(1);
    cur_code                 = KW'(int'(row_idx) * COLS + int'(lat_col));
    // First repeat waits REPEAT_DELAY held ticks, later ones REPEAT_RATE.
    rep_hit = 1'b0;
    if (REPEAT_DELAY != 0) begin
      rep_hit = rep_armed ? (rep_cnt == PW'(REPEAT_RATE - 1))
                          : (rep_cnt == PW'(REPEAT_DELAY - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_SCAN;
      row_idx    <= '0;
      row_n      <= ~ROWS'(1);
      lat_col    <= '0;
      cnt        <= '0;
      rep_cnt    <= '0;
      rep_armed  <= 1'b0;
      key_code   <= '0;
      key_valid  <= 1'b0;
      multi_key  <= 1'b0;
      new_evt    <= 1'b0;
      new_code   <= '0;
      new_repeat <= 1'b0;
    end else begin
      new_evt <= 1'b0;
      if (tick) begin
        case (state)
          ST_SCAN: begin
            if (any_pressed) begin
              lat_col <= low_col;
              cnt     <= DW'(1);
              state   <= ST_DEBOUNCE;
            end else begin
              row_idx <= next_row;
              row_n   <= ~(ROWS'(1) << next_row);
            end
          end
          ST_DEBOUNCE: begin
            if (any_pressed && low_col == lat_col) begin
              if (int'(cnt) + 1 >= DEBOUNCE) begin
                state      <= ST_PRESSED;
                key_valid  <= 1'b1;
                key_code   <= cur_code;
                multi_key  <= multi_now;
                rep_cnt    <= '0;
                rep_armed  <= 1'b0;
                new_evt    <= 1'b1;
                new_code   <= cur_code;
                new_repeat <= 1'b0;
              end else begin
                cnt <= cnt + DW'(1);
              end
            end else begin
              state   <= ST_SCAN;
              row_idx <= next_row;
              row_n   <= ~(ROWS'(1) << next_row);
            end
          end
          ST_PRESSED: begin
            if (any_pressed) begin
              multi_key <= multi_now;
              if (REPEAT_DELAY != 0) begin
                if (rep_hit) begin
                  rep_cnt    <= '0;
                  rep_armed  <= 1'b1;
                  new_evt    <= 1'b1;
                  new_code   <= key_code;
                  new_repeat <= 1'b1;
                end else begin
                  rep_cnt <= rep_cnt + PW'(1);
                end
              end
            end else begin
              cnt   <= DW'(1);
              state <= ST_RELEASE;
            end
          end
          ST_RELEASE: begin
            if (!any_pressed) begin
              if (int'(cnt) + 1 >= DEBOUNCE) begin
                state     <= ST_SCAN;
                row_idx   <= next_row;
                row_n     <= ~(ROWS'(1) << next_row);
                key_valid <= 1'b0;
                multi_key <= 1'b0;
              end else begin
                cnt <= cnt + DW'(1);
              end
            end else begin
              state <= ST_PRESSED;
            end
          end
          default: state <= ST_SCAN;
        endcase
      end
    end
  end

  // A handshake in the same cycle frees the slot, so a coincident event is not an overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      evt_valid  <= 1'b0;
      evt_code   <= '0;
      evt_repeat <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (new_evt && (!evt_valid || evt_ready)) begin
        evt_valid  <= 1'b1;
        evt_code   <= new_code;
        evt_repeat <= new_repeat;
      end else if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
      end
      if (new_evt && evt_valid && !evt_ready) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed and randomized bench for keypad_matrix_scanner using a simulated
// 4x4 switch matrix and an event-sequence model derived from held-tick counts.
module tb_keypad_matrix_scanner;

  localparam int ROWS         = 4;
  localparam int COLS         = 4;
  localparam int CLK_DIV      = 4;
  localparam int DEBOUNCE     = 3;
  localparam int REPEAT_DELAY = 8;
  localparam int REPEAT_RATE  = 4;

  typedef struct packed {
    logic [3:0] code;
    logic       rep;
  } evt_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [3:0] key_code;
  logic       key_valid, multi_key, evt_valid, evt_ready, evt_repeat, overflow, ovf_clr;
  logic [3:0] evt_code;
  logic [15:0] key_map;

  int   checks = 0;
  int   errors = 0;
  evt_t seen[$];
  evt_t expected[$];

  keypad_matrix_scanner #(
    .ROWS(ROWS), .COLS(COLS), .CLK_DIV(CLK_DIV), .DEBOUNCE(DEBOUNCE),
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)
  ) dut (
    .clk(clk), .reset(reset), .col_n(col_n), .row_n(row_n),
    .key_code(key_code), .key_valid(key_valid), .multi_key(multi_key),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
    .evt_repeat(evt_repeat), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  // Passive switch matrix: a closed switch pulls its column low while its row is driven.
  always_comb begin
    col_n = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!row_n[r] && key_map[r*COLS+c]) col_n[c] = 1'b0;
  end

  always @(negedge clk) begin
    if (!reset && evt_valid && evt_ready) seen.push_back({evt_code, evt_repeat});
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input int r, input int c, input logic v);
    key_map[r*COLS+c] = v;
  endtask

  task automatic wait_key_valid(input logic level, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (key_valid !== level && n < 400);
    check_output(tag, key_valid, level);
  endtask

  task automatic wait_row(input logic [3:0] value, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (row_n !== value && n < 60);
    check_output(tag, row_n, value);
  endtask

  // One initial event, then repeats at held ticks DELAY, DELAY+RATE, ... up to held.
  task automatic expect_hold(input int code, input int held);
    expected.delete();
    expected.push_back({4'(code), 1'b0});
    for (int h = REPEAT_DELAY; h <= held; h += REPEAT_RATE)
      expected.push_back({4'(code), 1'b1});
  endtask

  task automatic compare_events(input string tag);
    check_output({tag, "_count"}, seen.size(), expected.size());
    for (int i = 0; i < expected.size() && i < seen.size(); i++) begin
      check_output({tag, "_code"}, seen[i].code, expected[i].code);
      check_output({tag, "_rep"}, seen[i].rep, expected[i].rep);
    end
  endtask

  task automatic press_hold(input int r, input int c, input int held, input string tag);
    seen.delete();
    apply_stimulus(r, c, 1'b1);
    wait_key_valid(1'b1, {tag, "_press"});
    check_output({tag, "_key_code"}, key_code, r*COLS + c);
    repeat (CLK_DIV * held) @(negedge clk);
    apply_stimulus(r, c, 1'b0);
    wait_key_valid(1'b0, {tag, "_release"});
    repeat (3) @(negedge clk);
    expect_hold(r*COLS + c, held);
    compare_events(tag);
  endtask

  initial begin
    reset     = 1'b1;
    evt_ready = 1'b1;
    ovf_clr   = 1'b0;
    key_map   = '0;
    repeat (3) @(negedge clk);
    check_output("rst_row_n", row_n, 4'b1110);
    check_output("rst_key_valid", key_valid, 1'b0);
    check_output("rst_key_code", key_code, 4'h0);
    check_output("rst_multi_key", multi_key, 1'b0);
    check_output("rst_evt_valid", evt_valid, 1'b0);
    check_output("rst_evt_code", evt_code, 4'h0);
    check_output("rst_overflow", overflow, 1'b0);
    reset = 1'b0;

    // Idle scan: row advances on every fourth edge after reset release.
    repeat (3) @(negedge clk);
    check_output("scan_p3", row_n, 4'b1110);
    @(negedge clk);
    check_output("scan_p4", row_n, 4'b1101);
    repeat (3) @(negedge clk);
    check_output("scan_p7", row_n, 4'b1101);
    @(negedge clk);
    check_output("scan_p8", row_n, 4'b1011);
    repeat (4) @(negedge clk);
    check_output("scan_p12", row_n, 4'b0111);
    repeat (4) @(negedge clk);
    check_output("scan_p16", row_n, 4'b1110);

    // Single press of (2,1), release completes on the third released tick.
    seen.delete();
    apply_stimulus(2, 1, 1'b1);
    wait_key_valid(1'b1, "t2_press");
    check_output("t2_key_code", key_code, 4'd9);
    check_output("t2_multi_key", multi_key, 1'b0);
    repeat (CLK_DIV * 3) @(negedge clk);
    apply_stimulus(2, 1, 1'b0);
    repeat (11) @(negedge clk);
    check_output("t2_valid_before", key_valid, 1'b1);
    @(negedge clk);
    check_output("t2_valid_after", key_valid, 1'b0);
    check_output("t2_row_resume", row_n, 4'b0111);
    repeat (2) @(negedge clk);
    expect_hold(9, 3);
    compare_events("t2");

    // Bounce on (1,3): detected for one tick only, then scanning moves on.
    seen.delete();
    wait_row(4'b1101, "t3_row1");
    apply_stimulus(1, 3, 1'b1);
    repeat (4) @(negedge clk);
    check_output("t3_row_held", row_n, 4'b1101);
    apply_stimulus(1, 3, 1'b0);
    repeat (4) @(negedge clk);
    check_output("t3_row_next", row_n, 4'b1011);
    check_output("t3_key_valid", key_valid, 1'b0);
    repeat (8) @(negedge clk);
    check_output("t3_no_event", seen.size(), 0);

    press_hold(0, 0, 20, "t4_repeat");

    // Stalled consumer: second event is dropped and overflow sticks until cleared.
    evt_ready = 1'b0;
    apply_stimulus(3, 2, 1'b1);
    wait_key_valid(1'b1, "t5_a_press");
    check_output("t5_a_code", key_code, 4'd14);
    repeat (CLK_DIV * 2) @(negedge clk);
    apply_stimulus(3, 2, 1'b0);
    wait_key_valid(1'b0, "t5_a_release");
    check_output("t5_pending", evt_valid, 1'b1);
    check_output("t5_pending_code", evt_code, 4'd14);
    check_output("t5_no_ovf_yet", overflow, 1'b0);
    apply_stimulus(0, 1, 1'b1);
    wait_key_valid(1'b1, "t5_b_press");
    @(negedge clk);
    check_output("t5_overflow", overflow, 1'b1);
    check_output("t5_code_kept", evt_code, 4'd14);
    check_output("t5_rep_kept", evt_repeat, 1'b0);
    apply_stimulus(0, 1, 1'b0);
    wait_key_valid(1'b0, "t5_b_release");
    check_output("t5_sticky", overflow, 1'b1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check_output("t5_ovf_clr", overflow, 1'b0);
    evt_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_output("t5_drained", evt_valid, 1'b0);

    // Two keys on row 1: lowest column wins; dropping one keeps the key held.
    seen.delete();
    apply_stimulus(1, 0, 1'b1);
    apply_stimulus(1, 3, 1'b1);
    wait_key_valid(1'b1, "t6_press");
    check_output("t6_key_code", key_code, 4'd4);
    repeat (CLK_DIV) @(negedge clk);
    check_output("t6_multi_key", multi_key, 1'b1);
    apply_stimulus(1, 0, 1'b0);
    repeat (CLK_DIV * 4) @(negedge clk);
    check_output("t6_still_valid", key_valid, 1'b1);
    check_output("t6_still_code", key_code, 4'd4);
    check_output("t6_no_new_evt", seen.size(), 1);
    apply_stimulus(1, 3, 1'b0);
    wait_key_valid(1'b0, "t6_release");
    repeat (3) @(negedge clk);
    expect_hold(4, 5);
    compare_events("t6");

    // Reset while a key is held and an event is pending.
    evt_ready = 1'b0;
    apply_stimulus(2, 2, 1'b1);
    wait_key_valid(1'b1, "t7_press");
    repeat (2) @(negedge clk);
    check_output("t7_pending", evt_valid, 1'b1);
    reset = 1'b1;
    apply_stimulus(2, 2, 1'b0);
    @(negedge clk);
    check_output("t7_row_n", row_n, 4'b1110);
    check_output("t7_key_valid", key_valid, 1'b0);
    check_output("t7_evt_valid", evt_valid, 1'b0);
    check_output("t7_overflow", overflow, 1'b0);
    repeat (2) @(negedge clk);
    reset     = 1'b0;
    evt_ready = 1'b1;

    for (int i = 0; i < 6; i++) begin
      int r, c, h;
      r = $urandom_range(0, ROWS - 1);
      c = $urandom_range(0, COLS - 1);
      h = $urandom_range(1, 22);
      press_hold(r, c, h, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
